// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the framebuffer write packer.
package fb_pkg;
  localparam int unsigned SLOT_W       = 32;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned LINE_STRIDE  = 160;
  localparam int unsigned WORD_W       = PIX_PER_WORD * SLOT_W;
  localparam int unsigned MASK_W       = PIX_PER_WORD * 4;
  localparam int unsigned SLOT_IDX_W   = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    ACTIVE     = 2'd1,
    DONE       = 2'd2
  } fb_state_e;
endpackage

// File: rtl/fb_write_packer_if.sv
// Word write channel from the packer towards the DDR3 write arbiter.
interface fb_write_packer_if import fb_pkg::*; #(
  parameter int unsigned ADDR_BITS = 21
) ();
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WORD_W-1:0]    wr_data;
  logic [MASK_W-1:0]    wr_mask;

  modport master (output wr_valid, wr_addr, wr_data, wr_mask, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, wr_mask, output wr_ready);
endinterface

// File: rtl/fb_word_fifo.sv
// Small synchronous FIFO of {addr,data,mask} words; push on full succeeds when popping.
module fb_word_fifo import fb_pkg::*; #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITS = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [ADDR_BITS-1:0] push_addr,
  input  logic [WORD_W-1:0]    push_data,
  input  logic [MASK_W-1:0]    push_mask,
  input  logic                 pop,
  output logic                 empty,
  output logic                 dropped,
  output logic [ADDR_BITS-1:0] head_addr,
  output logic [WORD_W-1:0]    head_data,
  output logic [MASK_W-1:0]    head_mask
);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = ADDR_BITS + WORD_W + MASK_W;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, pop_ok, push_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dropped = push && !push_ok;
  assign {head_addr, head_data, head_mask} = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {push_addr, push_data, push_mask};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fb_write_packer.sv
// Framebuffer pixel-write receiver: tracks raster position, packs pixels into DDR words.
// Optional double buffering is enabled with FB_DOUBLE_BUF_EN (adds disp_buf output).
module fb_write_packer import fb_pkg::*; #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned COLOR_BITS = 18,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_BITS  = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           fb_width,
  input  logic [9:0]            fb_height,
  input  logic                  fb_vsync,
  input  logic                  fb_we,
  input  logic [COLOR_BITS-1:0] fb_data,
  fb_write_packer_if.master     wr_if,
  output logic [15:0]           frame_cnt,
  output logic                  overflow,
  output logic                  extra_px
`ifdef FB_DOUBLE_BUF_EN
  ,
  output logic                  disp_buf
`endif
);
  localparam int unsigned X_W = $clog2(WIDTH + 1);
  localparam int unsigned Y_W = $clog2(HEIGHT + 1);

  fb_state_e              state, state_nxt;
  logic [10:0]            width_q;
  logic [9:0]             height_q;
  logic [X_W-1:0]         x, eff_x;
  logic [Y_W-1:0]         y, eff_y;
  logic [SLOT_IDX_W-1:0]  slot, eff_slot;
  logic [WORD_W-1:0]      acc_data, eff_data, pix_data, push_data;
  logic [MASK_W-1:0]      acc_mask, eff_mask, pix_mask, push_mask;
  logic [ADDR_BITS-1:0]   cur_addr, line_base, eff_addr, eff_base, push_addr, frame_base_nxt;
  logic [10:0]            eff_w;
  logic [9:0]             eff_h;
  logic                   pix_ok, last_x, last_y, word_done, flush, push, fifo_empty, fifo_drop;
`ifdef FB_DOUBLE_BUF_EN
  logic                   buf_sel, eff_buf;

  assign eff_buf        = fb_vsync ? ~buf_sel : buf_sel;
  assign frame_base_nxt = eff_buf ? ADDR_BITS'(LINE_STRIDE * HEIGHT) : '0;
`else
  assign frame_base_nxt = '0;
`endif

  // A vsync in the same cycle as fb_we restarts the raster before the pixel is placed.
  always_comb begin
    eff_w     = fb_vsync ? fb_width  : width_q;
    eff_h     = fb_vsync ? fb_height : height_q;
    eff_x     = fb_vsync ? '0 : x;
    eff_y     = fb_vsync ? '0 : y;
    eff_slot  = fb_vsync ? '0 : slot;
    eff_data  = fb_vsync ? '0 : acc_data;
    eff_mask  = fb_vsync ? '0 : acc_mask;
    eff_addr  = fb_vsync ? frame_base_nxt : cur_addr;
    eff_base  = fb_vsync ? frame_base_nxt : line_base;
    pix_ok    = fb_we && (fb_vsync || state == ACTIVE);
    last_x    = (eff_x == X_W'(eff_w - 11'd1));
    last_y    = (eff_y == Y_W'(eff_h - 10'd1));
    pix_data  = eff_data;
    pix_mask  = eff_mask;
    for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
      if (eff_slot == SLOT_IDX_W'(i)) begin
        pix_data[i*SLOT_W +: SLOT_W] = SLOT_W'(fb_data);
        pix_mask[i*4 +: 4]           = '1;
      end
    end
    word_done = pix_ok && ((eff_slot == SLOT_IDX_W'(PIX_PER_WORD - 1)) || last_x);
    // Mid-frame flush owns the single push slot; a 1-pixel-wide new line in that cycle is lost.
    flush     = fb_vsync && (state == ACTIVE) && (acc_mask != '0);
    push      = flush || word_done;
    push_addr = flush ? cur_addr : eff_addr;
    push_data = flush ? acc_data : pix_data;
    push_mask = flush ? acc_mask : pix_mask;
  end

  always_comb begin
    state_nxt = state;
    if (fb_vsync) state_nxt = ACTIVE;
    if (pix_ok && last_x && last_y) state_nxt = DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_VSYNC;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q   <= '0;
      height_q  <= '0;
      x         <= '0;
      y         <= '0;
      slot      <= '0;
      acc_data  <= '0;
      acc_mask  <= '0;
      cur_addr  <= '0;
      line_base <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
      extra_px  <= 1'b0;
`ifdef FB_DOUBLE_BUF_EN
      buf_sel   <= 1'b1;
      disp_buf  <= 1'b0;
`endif
    end else begin
      if (fb_vsync) begin
        width_q   <= fb_width;
        height_q  <= fb_height;
        frame_cnt <= frame_cnt + 16'd1;
`ifdef FB_DOUBLE_BUF_EN
        buf_sel   <= ~buf_sel;
`endif
      end
      if (pix_ok) begin
        acc_data <= word_done ? '0 : pix_data;
        acc_mask <= word_done ? '0 : pix_mask;
        slot     <= word_done ? '0 : eff_slot + 1'b1;
        if (last_x) begin
          x         <= '0;
          y         <= eff_y + 1'b1;
          line_base <= eff_base + ADDR_BITS'(LINE_STRIDE);
          cur_addr  <= eff_base + ADDR_BITS'(LINE_STRIDE);
        end else begin
          x         <= eff_x + 1'b1;
          y         <= eff_y;
          line_base <= eff_base;
          cur_addr  <= word_done ? eff_addr + 1'b1 : eff_addr;
        end
      end else if (fb_vsync) begin
        x         <= '0;
        y         <= '0;
        slot      <= '0;
        acc_data  <= '0;
        acc_mask  <= '0;
        line_base <= frame_base_nxt;
        cur_addr  <= frame_base_nxt;
      end
      if (fifo_drop) overflow <= 1'b1;
      if (fb_we && !fb_vsync && state == DONE) extra_px <= 1'b1;
`ifdef FB_DOUBLE_BUF_EN
      if (pix_ok && last_x && last_y) disp_buf <= eff_buf;
`endif
    end
  end

  assign wr_if.wr_valid = ~fifo_empty;

  fb_word_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (push_addr),
    .push_data (push_data),
    .push_mask (push_mask),
    .pop       (wr_if.wr_ready),
    .empty     (fifo_empty),
    .dropped   (fifo_drop),
    .head_addr (wr_if.wr_addr),
    .head_data (wr_if.wr_data),
    .head_mask (wr_if.wr_mask)
  );
endmodule

// File: tb/tb_fb_write_packer.sv
// Scoreboard bench for fb_write_packer: directed frames, expected words queued, monitor compares.
module tb_fb_write_packer;
  import fb_pkg::*;

  localparam int unsigned AB = 21;
`ifdef FB_DOUBLE_BUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef struct packed {
    logic [AB-1:0]     addr;
    logic [WORD_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] fb_width;
  logic [9:0]  fb_height;
  logic        fb_vsync, fb_we;
  logic [17:0] fb_data;
  logic [15:0] frame_cnt;
  logic        overflow, extra_px;
`ifdef FB_DOUBLE_BUF_EN
  logic        disp_buf;
`endif

  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  fb_write_packer_if #(.ADDR_BITS(AB)) wr_bus ();

  fb_write_packer #(
    .WIDTH      (640),
    .HEIGHT     (480),
    .COLOR_BITS (18),
    .FIFO_DEPTH (4),
    .ADDR_BITS  (AB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fb_width  (fb_width),
    .fb_height (fb_height),
    .fb_vsync  (fb_vsync),
    .fb_we     (fb_we),
    .fb_data   (fb_data),
    .wr_if     (wr_bus),
    .frame_cnt (frame_cnt),
    .overflow  (overflow),
    .extra_px  (extra_px)
`ifdef FB_DOUBLE_BUF_EN
    ,
    .disp_buf  (disp_buf)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] w4(input int unsigned p0, input int unsigned p1,
                                            input int unsigned p2, input int unsigned p3);
    return {32'(p3), 32'(p2), 32'(p1), 32'(p0)};
  endfunction

  function automatic logic [AB-1:0] base(input int unsigned frame);
    return (DBUF && (frame % 2 == 0)) ? AB'(160 * 480) : '0;
  endfunction

  task automatic expect_word(input logic [AB-1:0] a, input logic [WORD_W-1:0] d,
                             input logic [MASK_W-1:0] m);
    word_t w;
    w.addr = a;
    w.data = d;
    w.mask = m;
    exp_q.push_back(w);
  endtask

  task automatic drive(input logic vs, input logic we, input int unsigned d,
                       input logic [10:0] w, input logic [9:0] h);
    fb_vsync  = vs;
    fb_we     = we;
    fb_data   = 18'(d);
    fb_width  = w;
    fb_height = h;
    @(posedge clk);
    #1;
    fb_vsync = 1'b0;
    fb_we    = 1'b0;
  endtask

  task automatic pixels(input int unsigned first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b1, first + i, fb_width, fb_height);
  endtask

  task automatic drain(input string name);
    for (int unsigned i = 0; i < 60 && (exp_q.size() != 0 || wr_bus.wr_valid); i++)
      @(posedge clk);
    @(posedge clk);
    #1;
    chk({name, "_pending"}, 128'(exp_q.size()), 128'd0);
    chk({name, "_valid_low"}, 128'(wr_bus.wr_valid), 128'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && wr_bus.wr_valid && wr_bus.wr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got addr %0h data %0h mask %0h, none expected",
                 wr_bus.wr_addr, wr_bus.wr_data, wr_bus.wr_mask);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        chk("word_addr", 128'(wr_bus.wr_addr), 128'(e.addr));
        chk("word_data", 128'(wr_bus.wr_data), 128'(e.data));
        chk("word_mask", 128'(wr_bus.wr_mask), 128'(e.mask));
      end
    end
  end

  initial begin
    rst = 1'b1;
    fb_width = 11'd8;
    fb_height = 10'd2;
    fb_vsync = 1'b0;
    fb_we = 1'b0;
    fb_data = '0;
    wr_bus.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(wr_bus.wr_valid), 128'd0);
    chk("rst_addr", 128'(wr_bus.wr_addr), 128'd0);
    chk("rst_data", 128'(wr_bus.wr_data), 128'd0);
    chk("rst_mask", 128'(wr_bus.wr_mask), 128'd0);
    chk("rst_frame_cnt", 128'(frame_cnt), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_extra_px", 128'(extra_px), 128'd0);
    rst = 1'b0;

    // Pixels before any vsync are dropped silently.
    pixels(100, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("prevsync_valid", 128'(wr_bus.wr_valid), 128'd0);
    chk("prevsync_extra_px", 128'(extra_px), 128'd0);
    chk("prevsync_state", 128'(dut.state), 128'(WAIT_VSYNC));

    // Frame 1: 8x2, pixels 1..16.
    expect_word(base(1) + 0,   w4(1, 2, 3, 4),     16'hFFFF);
    expect_word(base(1) + 1,   w4(5, 6, 7, 8),     16'hFFFF);
    expect_word(base(1) + 160, w4(9, 10, 11, 12),  16'hFFFF);
    expect_word(base(1) + 161, w4(13, 14, 15, 16), 16'hFFFF);
    drive(1'b1, 1'b0, 0, 11'd8, 10'd2);
    pixels(1, 16);
    chk("f1_state_done", 128'(dut.state), 128'(DONE));
    drain("f1");
    chk("f1_frame_cnt", 128'(frame_cnt), 128'd1);
`ifdef FB_DOUBLE_BUF_EN
    chk("f1_disp_buf", 128'(disp_buf), 128'd0);
`endif

    // Frame 2: 6x1, trailing partial word.
    expect_word(base(2) + 0, w4(21, 22, 23, 24), 16'hFFFF);
    expect_word(base(2) + 1, w4(25, 26, 0, 0),   16'h00FF);
    drive(1'b1, 1'b0, 0, 11'd6, 10'd1);
    pixels(21, 6);
    chk("f2_state_done", 128'(dut.state), 128'(DONE));
    drain("f2");
    chk("f2_frame_cnt", 128'(frame_cnt), 128'd2);
`ifdef FB_DOUBLE_BUF_EN
    chk("f2_disp_buf", 128'(disp_buf), 128'd1);
`endif

    // Pixel after frame complete.
    chk("extra_px_before", 128'(extra_px), 128'd0);
    pixels(60, 1);
    chk("extra_px_after", 128'(extra_px), 128'd1);
    drain("extra");

    // Frame 3 cut short by vsync carrying the first pixel of frame 4.
    expect_word(base(3) + 0,   w4(31, 32, 33, 0),  16'h0FFF);
    expect_word(base(4) + 0,   w4(40, 41, 42, 43), 16'hFFFF);
    expect_word(base(4) + 1,   w4(44, 45, 46, 47), 16'hFFFF);
    expect_word(base(4) + 160, w4(48, 49, 50, 51), 16'hFFFF);
    expect_word(base(4) + 161, w4(52, 53, 54, 55), 16'hFFFF);
    drive(1'b1, 1'b0, 0, 11'd8, 10'd2);
    pixels(31, 3);
    drive(1'b1, 1'b1, 40, 11'd8, 10'd2);
    pixels(41, 15);
    drain("restart");
    chk("restart_frame_cnt", 128'(frame_cnt), 128'd4);
    chk("restart_overflow", 128'(overflow), 128'd0);
`ifdef FB_DOUBLE_BUF_EN
    chk("restart_disp_buf", 128'(disp_buf), 128'd1);
`endif

    // Frame 5: arbiter stalled, six words produced, FIFO holds four.
    wr_bus.wr_ready = 1'b0;
    expect_word(base(5) + 0, w4(1, 2, 3, 4),     16'hFFFF);
    expect_word(base(5) + 1, w4(5, 6, 7, 8),     16'hFFFF);
    expect_word(base(5) + 2, w4(9, 10, 11, 12),  16'hFFFF);
    expect_word(base(5) + 3, w4(13, 14, 15, 16), 16'hFFFF);
    drive(1'b1, 1'b0, 0, 11'd640, 10'd480);
    pixels(1, 24);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_flag", 128'(overflow), 128'd1);
    chk("ovf_valid", 128'(wr_bus.wr_valid), 128'd1);
    chk("ovf_hold_addr", 128'(wr_bus.wr_addr), 128'(base(5)));
    chk("ovf_hold_data", 128'(wr_bus.wr_data), 128'(w4(1, 2, 3, 4)));
    chk("ovf_frame_cnt", 128'(frame_cnt), 128'd5);
    wr_bus.wr_ready = 1'b1;
    drain("ovf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
